// File: rtl/e_muldiv.sv
// e_muldiv: multi-cycle multiply/divide unit with the HI/LO registers. It lives in
// the Execute stage of the MIPS pipeline.
//
// An op accepted in IDLE has its full result computed at acceptance time. The result
// is parked in r_res_hi/r_res_lo. The unit then stays busy for a fixed number of
// cycles before it commits that result to the architectural HI/LO registers. This
// mimics the latency of an iterative unit without its datapath.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high; aborts any run in flight
//   i_md_op      0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   i_a, i_b     forwarded rs/rt operands, sampled only at the accepting edge
//   o_busy       multiply/divide run in progress
//   o_md_stall   busy OR an arithmetic md op waiting in E (to hazard unit)
//   o_hi, o_lo   architectural HI/LO (MFHI/MFLO source)
module e_muldiv #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_md_stall,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_BITS   = $clog2(MAX_CYCLES + 1);
    localparam int unsigned CNT_W      = (CNT_BITS > 4) ? CNT_BITS : 4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_res_hi;
    logic [31:0]      r_res_lo;
    logic             r_div0;

    logic             w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [31:0]      w_hi_d;
    logic [31:0]      w_lo_d;
    logic [31:0]      w_res_hi_d;
    logic [31:0]      w_res_lo_d;
    logic             w_div0_d;

    // Arithmetic datapath, evaluated on the current operands.
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic               w_b_zero;
    logic [31:0]        w_b_safe;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_squo_mag;
    logic [31:0]        w_srem_mag;
    logic [31:0]        w_squo;
    logic [31:0]        w_srem;
    logic [31:0]        w_uquo;
    logic [31:0]        w_urem;

    assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    // A zero divisor is replaced by 1 so the dividers never see it. The result is
    // discarded at commit anyway because r_div0 is set.
    assign w_b_zero = (i_b == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : i_b;

    // Signed divide is done on magnitudes. The quotient is truncated toward zero and
    // the remainder takes the dividend's sign. With this scheme 0x80000000 / -1
    // wraps to 0x80000000 with remainder 0, and no special case is needed.
    assign w_a_mag    = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_b_mag    = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
    assign w_squo_mag = w_a_mag / w_b_mag;
    assign w_srem_mag = w_a_mag % w_b_mag;
    assign w_squo     = (i_a[31] ^ i_b[31]) ? (32'd0 - w_squo_mag) : w_squo_mag;
    assign w_srem     = i_a[31] ? (32'd0 - w_srem_mag) : w_srem_mag;
    assign w_uquo     = i_a / w_b_safe;
    assign w_urem     = i_a % w_b_safe;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        w_res_hi_d = r_res_hi;
        w_res_lo_d = r_res_lo;
        w_div0_d   = r_div0;

        if (r_state == ST_IDLE) begin
            case (i_md_op)
                OP_MULT: begin
                    w_res_hi_d = w_smul[63:32];
                    w_res_lo_d = w_smul[31:0];
                    w_div0_d   = 1'b0;
                    w_cnt_d    = CNT_W'(MULT_CYCLES);
                    w_state_d  = ST_RUN;
                end
                OP_MULTU: begin
                    w_res_hi_d = w_umul[63:32];
                    w_res_lo_d = w_umul[31:0];
                    w_div0_d   = 1'b0;
                    w_cnt_d    = CNT_W'(MULT_CYCLES);
                    w_state_d  = ST_RUN;
                end
                OP_DIV: begin
                    w_res_hi_d = w_srem;
                    w_res_lo_d = w_squo;
                    w_div0_d   = w_b_zero;
                    w_cnt_d    = CNT_W'(DIV_CYCLES);
                    w_state_d  = ST_RUN;
                end
                OP_DIVU: begin
                    w_res_hi_d = w_urem;
                    w_res_lo_d = w_uquo;
                    w_div0_d   = w_b_zero;
                    w_cnt_d    = CNT_W'(DIV_CYCLES);
                    w_state_d  = ST_RUN;
                end
                OP_MTHI: w_hi_d = i_a;
                OP_MTLO: w_lo_d = i_a;
                default: ;
            endcase
        end else begin
            // Ops arriving while running are ignored. The hazard unit keeps them out of E.
            w_cnt_d = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                if (!r_div0) begin
                    w_hi_d = r_res_hi;
                    w_lo_d = r_res_lo;
                end
                w_state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_div0   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_res_hi <= w_res_hi_d;
            r_res_lo <= w_res_lo_d;
            r_div0   <= w_div0_d;
        end
    end

    assign o_busy     = (r_state == ST_RUN);
    assign o_md_stall = o_busy || ((i_md_op >= OP_MULT) && (i_md_op <= OP_DIVU));
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule
